dm_write_handler: RTL and testbench

Data-memory-side responder for the shared write interface that a two-processor write arbiter drives. It accepts one write command of data, address and data type over the wr_ins/wr_idle handshake. It then serialises the command into little-endian byte writes on a byte-wide RAM port, one byte per cycle. wr_idle reports busy to the arbiter until the last byte has been committed.

---
 rtl/dm_write_handler_pkg.sv | 20 ++
 rtl/dm_byte_ram.sv | 24 ++
 rtl/dm_write_handler.sv | 108 ++++++++++
 tb/tb_dm_write_handler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_write_handler_pkg.sv
// Shared definitions for the data-memory write path: data type codes, handler
// states and the byte count of each data type.
package dm_write_handler_pkg;

  localparam int DT_BYTE   = 0;
  localparam int DT_HALF   = 1;
  localparam int DT_WORD   = 2;
  localparam int DT_DOUBLE = 3;

  typedef enum logic {
    IDLE_STATE  = 1'b0,
    WRITE_STATE = 1'b1
  } state_t;

  // Number of bytes moved by one command of the given (already saturated) type.
  function automatic logic [3:0] bytes_of(input logic [1:0] data_type);
    return 4'd1 << data_type;
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Byte-wide data memory with one synchronous write port and one registered read port.
module dm_byte_ram #(
  parameter int DATA_MEMORY_SIZE = 1024,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int BYTE_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_WIDTH_DM-1:0] waddr,
  input  logic [BYTE_WIDTH-1:0]    wdata,
  input  logic [ADDR_WIDTH_DM-1:0] raddr,
  output logic [BYTE_WIDTH-1:0]    rdata
);

  logic [BYTE_WIDTH-1:0] mem [DATA_MEMORY_SIZE];

  // NOTE: the array and its read register are deliberately not reset, so the
  // storage can map onto a RAM macro; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dm_write_handler.sv
// Accepts one write command over wr_ins/wr_idle and serialises it into
// little-endian byte writes on the RAM port, one byte per cycle.
module dm_write_handler
  import dm_write_handler_pkg::*;
#(
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_MEMORY_SIZE = 1024,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = 2,
  parameter int BYTE_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr,
  input  logic [ADDR_WIDTH_DM-1:0]    addr_wr,
  input  logic [DATA_TYPE_WIDTH-1:0]  data_type_wr,
  input  logic                        wr_ins,
  output logic                        wr_idle,
  output logic                        mem_we,
  output logic [ADDR_WIDTH_DM-1:0]    mem_addr,
  output logic [BYTE_WIDTH-1:0]       mem_wdata,
  output logic                        wr_done,
  output logic                        misaligned
);

  localparam int CNT_W = 3;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DOUBLEWORD_WIDTH-1:0] data_q, data_d;
  logic                        mem_we_d, wr_done_d, misaligned_d;
  logic [ADDR_WIDTH_DM-1:0]    mem_addr_d, next_addr;
  logic [BYTE_WIDTH-1:0]       mem_wdata_d;
  logic [1:0]                  dt_eff;
  logic [3:0]                  n_bytes;
  logic                        last_byte, capture, addr_misaligned;

  assign wr_idle   = (state_q == IDLE_STATE) & ~wr_ins;
  assign last_byte = (state_q == WRITE_STATE) && (cnt_q == '0);
  // A request still held on the final-byte edge is taken at once, so
  // back-to-back commands stream with no gap cycle.
  assign capture   = wr_ins & ((state_q == IDLE_STATE) | last_byte);

  assign dt_eff  = (data_type_wr > DATA_TYPE_WIDTH'(DT_DOUBLE)) ? 2'(DT_DOUBLE) : data_type_wr[1:0];
  assign n_bytes = bytes_of(dt_eff);
  assign addr_misaligned = (addr_wr & ADDR_WIDTH_DM'(n_bytes - 4'd1)) != '0;
  assign next_addr = (mem_addr == ADDR_WIDTH_DM'(DATA_MEMORY_SIZE - 1)) ? '0
                                                                        : mem_addr + ADDR_WIDTH_DM'(1);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    wr_done_d    = 1'b0;
    misaligned_d = misaligned;
    if (capture) begin
      state_d      = WRITE_STATE;
      cnt_d        = CNT_W'(n_bytes - 4'd1);
      mem_we_d     = 1'b1;
      mem_addr_d   = addr_wr;
      mem_wdata_d  = data_bus_wr[BYTE_WIDTH-1:0];
      data_d       = data_bus_wr >> BYTE_WIDTH;
      wr_done_d    = (n_bytes == 4'd1);
      misaligned_d = misaligned | addr_misaligned;
    end else if (state_q == WRITE_STATE) begin
      if (last_byte) begin
        state_d = IDLE_STATE;
      end else begin
        cnt_d       = cnt_q - 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = next_addr;
        mem_wdata_d = data_q[BYTE_WIDTH-1:0];
        data_d      = data_q >> BYTE_WIDTH;
        wr_done_d   = (cnt_q == CNT_W'(1));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_STATE;
      cnt_q      <= '0;
      data_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_done    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      wr_done    <= wr_done_d;
      misaligned <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_dm_write_handler.sv
// Self-checking bench for dm_write_handler: directed scenarios plus random
// commands, checked against a byte-level write model and a shadow memory.
module tb_dm_write_handler;

  localparam int MEM = 1024;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   data_bus_wr = '0;
  logic [AW-1:0] addr_wr = '0;
  logic [1:0]    data_type_wr = '0;
  logic          wr_ins = 1'b0;
  logic          wr_idle, mem_we, wr_done, misaligned;
  logic [AW-1:0] mem_addr, rd_addr = '0;
  logic [7:0]    mem_wdata, rd_data;

  dm_write_handler dut (
    .clk(clk), .rst_n(rst_n), .data_bus_wr(data_bus_wr), .addr_wr(addr_wr),
    .data_type_wr(data_type_wr), .wr_ins(wr_ins), .wr_idle(wr_idle),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_done(wr_done), .misaligned(misaligned)
  );

  dm_byte_ram ram (
    .clk(clk), .we(mem_we), .waddr(mem_addr), .wdata(mem_wdata),
    .raddr(rd_addr), .rdata(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          done;
    bit            chain;  // must directly follow the previous write
  } wr_t;

  wr_t        obs_q[$], exp_q[$];
  logic [7:0] ref_mem [MEM];
  bit         ref_valid [MEM];
  bit         ref_mis;
  int         cyc, stray_done;
  int         checks, errors;

  always @(posedge clk) cyc++;

  // Recorder only: captures every byte write seen on the RAM port.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n && mem_we) begin
      w.cyc = cyc; w.addr = mem_addr; w.data = mem_wdata; w.done = wr_done; w.chain = 1'b0;
      obs_q.push_back(w);
    end
    if (rst_n && wr_done && !mem_we) stray_done++;
  end

  // Expected effect of a command: `limit` bytes written at (a+k) mod MEM.
  task automatic model_cmd(input int a, input int dt, input logic [63:0] d,
                           input int limit, input bit chain_first);
    int  n = 1 << dt;
    wr_t w;
    for (int k = 0; k < n && k < limit; k++) begin
      w.cyc = 0; w.addr = AW'((a + k) % MEM); w.data = 8'(d >> (8 * k));
      w.done = (k == n - 1); w.chain = (k > 0) || chain_first;
      exp_q.push_back(w);
      ref_mem[(a + k) % MEM] = w.data;
      ref_valid[(a + k) % MEM] = 1'b1;
    end
    if (a % n != 0) ref_mis = 1'b1;
  endtask

  // Index of the first disagreement between observed and expected writes, -1 if none.
  function automatic int first_diff(output string got_s, output string exp_s);
    got_s = $sformatf("%0d writes", obs_q.size());
    exp_s = $sformatf("%0d writes", exp_q.size());
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      got_s = $sformatf("addr %h data %h done %b cyc %0d", obs_q[i].addr, obs_q[i].data,
                        obs_q[i].done, obs_q[i].cyc);
      exp_s = $sformatf("addr %h data %h done %b%s", exp_q[i].addr, exp_q[i].data,
                        exp_q[i].done, exp_q[i].chain ? " consecutive" : "");
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].done !== exp_q[i].done) return i;
      if (i > 0 && exp_q[i].chain && obs_q[i].cyc != obs_q[i-1].cyc + 1) return i;
    end
    return -1;
  endfunction

  task automatic drive(input int a, input int dt, input logic [63:0] d);
    addr_wr = AW'(a); data_type_wr = 2'(dt); data_bus_wr = d; wr_ins = 1'b1;
  endtask

  // Cycles spent busy after the capture edge; bounded so a hung DUT still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (!wr_idle && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic read_ram(input int a, output logic [7:0] d);
    rd_addr = AW'(a); @(posedge clk); #1; d = rd_data;
  endtask

  task automatic start_scenario;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, wr_done, misaligned, wr_idle} !== {1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got we=%b addr=%h wdata=%h done=%b mis=%b idle=%b, expected 0 000 00 0 0 1",
               mem_we, mem_addr, mem_wdata, wr_done, misaligned, wr_idle);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte;
    int n, idx; string g, e;
    start_scenario();
    drive('h010, 0, 64'h0123_4567_89AB_CDAB); model_cmd('h010, 0, 64'h0123_4567_89AB_CDAB, 8, 0);
    #1;
    checks++;
    if (wr_idle !== 1'b0) begin errors++; $display("FAIL byte_idle_drop: got wr_idle=%b expected 0", wr_idle); end
    @(posedge clk); #1; wr_ins = 1'b0;
    wait_idle(n);
    checks++;
    if (n + 1 != 2) begin errors++; $display("FAIL byte_busy_cycles: got %0d expected 2", n + 1); end
    idx = first_diff(g, e); checks++;
    if (idx != -1) begin errors++; $display("FAIL byte_stream[%0d]: got %s expected %s", idx, g, e); end
    checks++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL byte_misaligned: got %b expected 0", misaligned); end
  endtask

  task automatic test_double;
    int n, idx; string g, e; logic [7:0] rd;
    start_scenario();
    drive('h100, 3, 64'h8877_6655_4433_2211); model_cmd('h100, 3, 64'h8877_6655_4433_2211, 8, 0);
    @(posedge clk); #1; wr_ins = 1'b0;
    wait_idle(n);
    checks++;
    if (n + 1 != 9) begin errors++; $display("FAIL double_busy_cycles: got %0d expected 9", n + 1); end
    idx = first_diff(g, e); checks++;
    if (idx != -1) begin errors++; $display("FAIL double_stream[%0d]: got %s expected %s", idx, g, e); end
    for (int a = 'h100; a < 'h108; a++) begin
      read_ram(a, rd); checks++;
      if (rd !== ref_mem[a]) begin errors++; $display("FAIL double_ram[%h]: got %h expected %h", a, rd, ref_mem[a]); end
    end
  endtask

  task automatic test_wrap_misalign;
    int n, idx; string g, e;
    start_scenario();
    drive('h3FE, 2, 64'hDDCC_BBAA); model_cmd('h3FE, 2, 64'hDDCC_BBAA, 8, 0);
    @(posedge clk); #1; wr_ins = 1'b0;
    wait_idle(n);
    idx = first_diff(g, e); checks++;
    if (idx != -1) begin errors++; $display("FAIL wrap_stream[%0d]: got %s expected %s", idx, g, e); end
    checks++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL wrap_misaligned: got %b expected 1", misaligned); end
  endtask

  task automatic test_back_to_back;
    int n, idx; string g, e;
    start_scenario();
    drive('h020, 1, 64'hBEEF); model_cmd('h020, 1, 64'hBEEF, 8, 0);
    @(posedge clk); #1;
    drive('h030, 0, 64'h5A); model_cmd('h030, 0, 64'h5A, 8, 1);
    @(posedge clk); #1;
    @(posedge clk); #1; wr_ins = 1'b0;
    wait_idle(n);
    idx = first_diff(g, e); checks++;
    if (idx != -1) begin errors++; $display("FAIL b2b_stream[%0d]: got %s expected %s", idx, g, e); end
  endtask

  task automatic test_busy_ignore;
    int n, idx; string g, e;
    start_scenario();
    drive('h040, 2, 64'h4433_2211); model_cmd('h040, 2, 64'h4433_2211, 8, 0);
    @(posedge clk); #1;
    wr_ins = 1'b0;
    @(posedge clk); #1;
    drive('h080, 0, 64'hEE);
    @(posedge clk); #1; wr_ins = 1'b0;
    wait_idle(n);
    idx = first_diff(g, e); checks++;
    if (idx != -1) begin errors++; $display("FAIL busy_stream[%0d]: got %s expected %s", idx, g, e); end
    checks++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL sticky_misaligned: got %b expected 1", misaligned); end
  endtask

  task automatic test_reset_mid;
    int n; logic [7:0] rd;
    logic [63:0] p = 64'hA7A6_A5A4_A3A2_A1A0, q = 64'h5756_5554_5352_5150;
    drive('h200, 3, p); model_cmd('h200, 3, p, 8, 0);
    @(posedge clk); #1; wr_ins = 1'b0;
    wait_idle(n);
    start_scenario();
    drive('h200, 3, q); model_cmd('h200, 3, q, 3, 0);
    @(posedge clk); #1; wr_ins = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", mem_we); end
    ref_mis = 1'b0;
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++;
    if ({wr_idle, misaligned, mem_addr, mem_wdata} !== {1'b1, 1'b0, 10'h0, 8'h0}) begin
      errors++;
      $display("FAIL abort_recover: got idle=%b mis=%b addr=%h wdata=%h expected 1 0 000 00",
               wr_idle, misaligned, mem_addr, mem_wdata);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_bytes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end
    for (int a = 'h200; a < 'h208; a++) begin
      read_ram(a, rd); checks++;
      if (rd !== ref_mem[a]) begin errors++; $display("FAIL abort_ram[%h]: got %h expected %h", a, rd, ref_mem[a]); end
    end
  endtask

  task automatic test_random;
    int n, idx, a, dt; logic [63:0] d; string g, e; logic [7:0] rd;
    start_scenario();
    stray_done = 0;
    for (int i = 0; i < 40; i++) begin
      dt = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, MEM - 1));
      if ($urandom_range(0, 1) == 0) a = a & ~((1 << dt) - 1);
      d  = {$urandom, $urandom};
      drive(a, dt, d); model_cmd(a, dt, d, 8, 0);
      @(posedge clk); #1;
      drive(int'($urandom_range(0, MEM - 1)), int'($urandom_range(0, 3)), {$urandom, $urandom});
      wr_ins = 1'b0;
      wait_idle(n);
      checks++;
      if (n != (1 << dt)) begin errors++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", i, n, 1 << dt); end
      checks++;
      if (misaligned !== ref_mis) begin errors++; $display("FAIL rand_misaligned[%0d]: got %b expected %b", i, misaligned, ref_mis); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    idx = first_diff(g, e); checks++;
    if (idx != -1) begin errors++; $display("FAIL rand_stream[%0d]: got %s expected %s", idx, g, e); end
    checks++;
    if (stray_done != 0) begin errors++; $display("FAIL rand_stray_done: got %0d expected 0", stray_done); end
    for (int k = 0; k < MEM; k++) begin
      if (ref_valid[k]) begin
        read_ram(k, rd); checks++;
        if (rd !== ref_mem[k]) begin errors++; $display("FAIL rand_ram[%h]: got %h expected %h", k, rd, ref_mem[k]); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; ref_mis = 1'b0;
    test_reset();
    test_byte();
    test_double();
    test_wrap_misalign();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
